// File: rtl/float_divider_seq_pkg.sv
// Shared single-precision float definitions: field widths, constants,
// FSM state encoding and operand classification helpers.
package float_pkg;

  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int QBITS    = 25;

  localparam logic [31:0] NAN_VALUE = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG   = 31'h7F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_DIV    = 3'd2,
    ST_PACK   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:0] == 31'd0);
  endfunction

  function automatic logic is_denormal(input logic [31:0] x);
    return (x[30:23] == 8'h00) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/float_divider_seq_if.sv
// Operand/result handshake bundle for the sequential float divider.
interface float_divider_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        error;
  logic        div_by_zero;
  logic        overflow;
  logic        underflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, error, div_by_zero, overflow, underflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, error, div_by_zero, overflow, underflow
  );
endinterface

// File: rtl/float_divider_seq_mantissa_divider.sv
// Radix-2 restoring mantissa divider: one quotient bit per clock, MSB first.
// done is high during the cycle that produces the final (LSB) quotient bit.
module mantissa_divider
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] ma,
  input  logic [23:0] mb,
  output logic [24:0] q,
  output logic        done
);

  logic [24:0] rem_r;
  logic [23:0] mb_r;
  logic [24:0] q_r;
  logic [4:0]  cnt_r;
  logic        busy_r;
  logic        ge_s;
  logic [24:0] diff_s;

  // Trial subtraction: keep the difference only when the divisor fits.
  always_comb begin
    ge_s   = (rem_r >= {1'b0, mb_r});
    diff_s = rem_r;
    if (ge_s) begin
      diff_s = rem_r - {1'b0, mb_r};
    end else begin
      diff_s = rem_r;
    end
  end

  // Iteration state: load on start, then shift in one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r  <= 25'd0;
      mb_r   <= 24'd0;
      q_r    <= 25'd0;
      cnt_r  <= 5'd0;
      busy_r <= 1'b0;
    end else if (start) begin
      rem_r  <= {1'b0, ma};
      mb_r   <= mb;
      q_r    <= 25'd0;
      cnt_r  <= 5'(QBITS - 1);
      busy_r <= 1'b1;
    end else if (busy_r) begin
      q_r[cnt_r] <= ge_s;
      // after a restoring step the remainder is below mb, so 24 bits suffice
      rem_r      <= {diff_s[23:0], 1'b0};
      if (cnt_r == 5'd0) begin
        busy_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - 5'd1;
      end
    end
  end

  assign q    = q_r;
  assign done = busy_r && (cnt_r == 5'd0);

endmodule

// File: rtl/float_divider_seq.sv
// Iterative IEEE-754 single-precision divider (a / b) with valid/ready
// handshakes. Special operands bypass the mantissa core; results truncate.
module float_divider_seq
  import float_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  float_divider_seq_if.slave  bus
);

  state_t      state_r, next_state_s;
  logic [31:0] a_r, b_r;
  logic        sign_r;
  logic signed [9:0] exp_r;
  logic        special_r, spec_error_r, spec_dbz_r;
  logic [31:0] spec_result_r;
  logic [31:0] result_r;
  logic        error_r, dbz_r, ovf_r, unf_r;
  logic        in_ready_r, out_valid_r;

  logic        sign_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic        special_s, spec_error_s, spec_dbz_s;
  logic [31:0] spec_result_s;
  logic signed [9:0] unpack_exp_s, pack_exp_s;
  logic [22:0] pack_mant_s;
  logic [31:0] pack_result_s;
  logic        pack_ovf_s, pack_unf_s;
  logic [24:0] q_s;
  logic        div_done_s, div_start_s;

  assign sign_s   = a_r[31] ^ b_r[31];
  assign a_nan_s  = is_nan(a_r);
  assign b_nan_s  = is_nan(b_r);
  assign a_inf_s  = is_inf(a_r);
  assign b_inf_s  = is_inf(b_r);
  // denormals are flushed to zero
  assign a_zero_s = is_zero(a_r) || is_denormal(a_r);
  assign b_zero_s = is_zero(b_r) || is_denormal(b_r);
  assign unpack_exp_s = $signed({2'b00, a_r[30:23]}) - $signed({2'b00, b_r[30:23]})
                      + 10'(EXP_BIAS);
  assign div_start_s  = (state_r == ST_UNPACK) && !special_s;

  mantissa_divider u_mdiv (
    .clk   (clk),
    .rst   (rst),
    .start (div_start_s),
    .ma    ({1'b1, a_r[22:0]}),
    .mb    ({1'b1, b_r[22:0]}),
    .q     (q_s),
    .done  (div_done_s)
  );

  // Special-operand classification in priority order.
  always_comb begin
    special_s     = 1'b1;
    spec_result_s = 32'h0000_0000;
    spec_error_s  = 1'b0;
    spec_dbz_s    = 1'b0;
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      spec_result_s = NAN_VALUE;
      spec_error_s  = 1'b1;
    end else if (b_zero_s && !a_inf_s) begin
      spec_result_s = {sign_s, INF_MAG};
      spec_dbz_s    = 1'b1;
    end else if (a_inf_s) begin
      spec_result_s = {sign_s, INF_MAG};
    end else if (a_zero_s || b_inf_s) begin
      spec_result_s = {sign_s, 31'd0};
    end else begin
      special_s = 1'b0;
    end
  end

  // Normalise the quotient, truncate, and clamp the exponent range.
  always_comb begin
    pack_exp_s    = exp_r;
    pack_mant_s   = q_s[23:1];
    pack_ovf_s    = 1'b0;
    pack_unf_s    = 1'b0;
    pack_result_s = 32'h0000_0000;
    if (q_s[24]) begin
      pack_mant_s = q_s[23:1];
      pack_exp_s  = exp_r;
    end else begin
      pack_mant_s = q_s[22:0];
      pack_exp_s  = exp_r - 10'sd1;
    end
    if (pack_exp_s >= 10'(EXP_MAX)) begin
      pack_result_s = {sign_r, INF_MAG};
      pack_ovf_s    = 1'b1;
    end else if (pack_exp_s <= 10'sd0) begin
      pack_result_s = {sign_r, 31'd0};
      pack_unf_s    = 1'b1;
    end else begin
      pack_result_s = {sign_r, pack_exp_s[7:0], pack_mant_s};
    end
  end

  // Next-state logic for the operation sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:   if (bus.in_valid)   next_state_s = ST_UNPACK; else next_state_s = ST_IDLE;
      ST_UNPACK: if (special_s)      next_state_s = ST_PACK;   else next_state_s = ST_DIV;
      ST_DIV:    if (div_done_s)     next_state_s = ST_PACK;   else next_state_s = ST_DIV;
      ST_PACK:   next_state_s = ST_DONE;
      ST_DONE:   if (bus.out_ready)  next_state_s = ST_IDLE;   else next_state_s = ST_DONE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // State register with registered handshake outputs derived from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == ST_IDLE);
      out_valid_r <= (next_state_s == ST_DONE);
    end
  end

  // Operand capture, unpack results and output holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r           <= 32'd0;
      b_r           <= 32'd0;
      sign_r        <= 1'b0;
      exp_r         <= 10'sd0;
      special_r     <= 1'b0;
      spec_result_r <= 32'd0;
      spec_error_r  <= 1'b0;
      spec_dbz_r    <= 1'b0;
      result_r      <= 32'd0;
      error_r       <= 1'b0;
      dbz_r         <= 1'b0;
      ovf_r         <= 1'b0;
      unf_r         <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && bus.in_valid) begin
        a_r <= bus.a;
        b_r <= bus.b;
      end
      if (state_r == ST_UNPACK) begin
        sign_r        <= sign_s;
        exp_r         <= unpack_exp_s;
        special_r     <= special_s;
        spec_result_r <= spec_result_s;
        spec_error_r  <= spec_error_s;
        spec_dbz_r    <= spec_dbz_s;
      end
      if (state_r == ST_PACK) begin
        result_r <= special_r ? spec_result_r : pack_result_s;
        error_r  <= special_r ? spec_error_r  : 1'b0;
        dbz_r    <= special_r ? spec_dbz_r    : 1'b0;
        ovf_r    <= special_r ? 1'b0          : pack_ovf_s;
        unf_r    <= special_r ? 1'b0          : pack_unf_s;
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.result      = result_r;
  assign bus.error       = error_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = ovf_r;
  assign bus.underflow   = unf_r;

endmodule

// File: tb/tb_float_divider_seq.sv
// Scoreboard bench for float_divider_seq: driver pushes model expectations,
// a negedge monitor pops and compares result, flags and latency.
module tb_float_divider_seq;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;   // {error, div_by_zero, overflow, underflow}
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_ov = 1'b0;

  float_divider_seq_if bus();

  float_divider_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer quotient of the significands, truncated.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [3:0] flags, output int lat);
    int ea, eb, e;
    longint fa, fb, q;
    logic s, an, bn, ai, bi, az, bz;
    logic [22:0] mant;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = longint'(a[22:0]); fb = longint'(b[22:0]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (fa != 0); bn = (eb == 255) && (fb != 0);
    ai = (ea == 255) && (fa == 0); bi = (eb == 255) && (fb == 0);
    az = (ea == 0);                bz = (eb == 0);
    lat = 2; flags = 4'b0000;
    if (an || bn || (az && bz) || (ai && bi)) begin
      res = 32'h7FC0_0000; flags = 4'b1000;
    end else if (bz && !ai) begin
      res = {s, 8'hFF, 23'd0}; flags = 4'b0100;
    end else if (ai) begin
      res = {s, 8'hFF, 23'd0};
    end else if (az || bi) begin
      res = {s, 31'd0};
    end else begin
      lat = 27;
      q = ((fa + 64'd8388608) * 64'd16777216) / (fb + 64'd8388608);
      e = ea - eb + 127;
      if (q >= 64'd16777216) begin
        mant = 23'((q / 2) % 64'd8388608);
      end else begin
        mant = 23'(q % 64'd8388608);
        e = e - 1;
      end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'd0}; flags = 4'b0010;
      end else if (e <= 0) begin
        res = {s, 31'd0}; flags = 4'b0001;
      end else begin
        res = {s, 8'(e), mant};
      end
    end
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: r[30:23] = 8'h00;
      1: r[30:23] = 8'hFF;
      2: r[30:0]  = 31'd0;
      3: r[30:23] = 8'hFE;
      4: r[30:23] = 8'h01;
      default: ;
    endcase
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv);
    int t;
    exp_t e;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL in_ready_timeout: got 0 want 1");
    end else begin
      bus.in_valid = 1'b1; bus.a = av; bus.b = bv;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      model(av, bv, e.res, e.flags, e.lat);
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
    repeat (4) @(negedge clk);
  endtask

  // Monitor: latency on out_valid rise, value check on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_output: got result %h want no output", bus.result);
        end else begin
          check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        end
      end
      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("result", bus.result, mon_e.res);
        check("flags", {28'd0, bus.error, bus.div_by_zero, bus.overflow, bus.underflow},
              {28'd0, mon_e.flags});
      end
      prev_ov = bus.out_valid;
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.a = 32'd0; bus.b = 32'd0; bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", {28'd0, bus.error, bus.div_by_zero, bus.overflow, bus.underflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    issue(32'h40C0_0000, 32'h4000_0000);
    issue(32'h3F80_0000, 32'h4040_0000);
    issue(32'hBF80_0000, 32'h4000_0000);
    issue(32'h3F80_0000, 32'h0000_0000);
    issue(32'h0000_0000, 32'h0000_0000);
    issue(32'h7F80_0000, 32'h7F80_0000);
    issue(32'h7FC0_0001, 32'h3F80_0000);
    issue(32'h7F00_0000, 32'h3E80_0000);
    issue(32'h0080_0000, 32'h4000_0000);
    drain();

    // randomized operands, biased toward special exponents
    for (int i = 0; i < 40; i++) begin
      issue(rand_fp(), rand_fp());
    end
    drain();

    // backpressure: result held, stray in_valid ignored
    bus.out_ready = 1'b0;
    issue(32'h40C0_0000, 32'h4000_0000);
    begin
      int t;
      t = 0;
      while (!bus.out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_result", bus.result, 32'h4040_0000);
      check("bp_flags", {28'd0, bus.error, bus.div_by_zero, bus.overflow, bus.underflow}, 32'd0);
      if (i == 1) begin
        bus.in_valid = 1'b1; bus.a = 32'h3F80_0000; bus.b = 32'h0000_0000;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_hold", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    drain();
    repeat (40) @(negedge clk);

    // reset in the middle of the mantissa iteration
    issue(32'h40C0_0000, 32'h4000_0000);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(32'h40C0_0000, 32'h4000_0000);
    drain();
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
